// File: rtl/task_loader.sv
// task_loader: buffers arrival-stamped task records and releases each one to the scheduler when its arrival time is reached.
// Optional late/drop statistics counters are built only when TASK_LOADER_STATS_EN is defined.
module task_loader #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [25:0] in_rec,
    output logic        inputtask,
    output logic [19:0] task_in,
    output logic        pending,
    output logic [7:0]  late_cnt,
    output logic [7:0]  drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 6;
    localparam int unsigned RW = 26;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0] timer_q;
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [RW-1:0] head;
    logic          full, empty, push, pop, eligible, zero_burst;

    assign head     = mem[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign pending  = !empty;
    assign push     = in_valid && !full;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the zero-latency release decision on the FIFO head.
    always_comb begin
        state_d    = state_q;
        eligible   = 1'b0;
        zero_burst = 1'b0;
        pop        = 1'b0;
        inputtask  = 1'b0;
        task_in    = '0;
        case (state_q)
            IDLE: begin
                if (st) state_d = RUN;
            end
            RUN: begin
                eligible   = !empty && (head[25:20] <= timer_q);
                zero_burst = (head[19:16] == 4'd0);
                pop        = eligible;
                inputtask  = eligible && !zero_burst;
                if (inputtask) task_in = head[19:0];
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer reads 0 in the first RUN cycle, matching the scheduler's timer.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) timer_q <= '0;
        else                        timer_q <= timer_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_rec;
    end

`ifdef TASK_LOADER_STATS_EN
    logic [7:0] late_q, drop_q;
    logic       late_ev, drop_ev;

    assign late_ev = inputtask && (head[25:20] < timer_q);
    assign drop_ev = pop && zero_burst;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            late_q <= '0;
            drop_q <= '0;
        end else begin
            if (late_ev && late_q != 8'hFF) late_q <= late_q + 8'd1;
            if (drop_ev && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign late_cnt = late_q;
    assign drop_cnt = drop_q;
`else
    assign late_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_task_loader.sv
// Bench for task_loader: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_task_loader;
    localparam int unsigned DEPTH = 8;
`ifdef TASK_LOADER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, st, in_valid, in_ready, inputtask, pending;
    logic [25:0] in_rec;
    logic [19:0] task_in;
    logic [7:0]  late_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .st(st), .in_valid(in_valid), .in_ready(in_ready),
        .in_rec(in_rec), .inputtask(inputtask), .task_in(task_in), .pending(pending),
        .late_cnt(late_cnt), .drop_cnt(drop_cnt)
    );

    // Reference model: a plain queue of records, a running flag and an integer clock.
    logic [25:0] mq[$];
    bit          m_run;
    int          m_tmr, m_late, m_drop;

    typedef struct {
        logic        r, s, v;
        logic [25:0] d;
        logic        it;
        logic [19:0] ti;
        logic        rdy, pend;
        logic [7:0]  late, drop;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [25:0] rec(int arr, int burst, int id);
        return {6'(arr), 4'(burst), 16'(id)};
    endfunction

    function automatic vec_t mk(logic r, logic s, logic v, logic [25:0] d, logic it,
                                logic [19:0] ti, logic rdy, logic pend, int late, int drop);
        vec_t x;
        x.r = r; x.s = s; x.v = v; x.d = d; x.it = it; x.ti = ti;
        x.rdy = rdy; x.pend = pend; x.late = 8'(late); x.drop = 8'(drop);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int stat(int v);
        return STATS ? v : 0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_run = 0; m_tmr = 0; m_late = 0; m_drop = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; st = 1'b0; in_valid = 1'b0; in_rec = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive, compare against model, advance both at the edge.
    task automatic cycle(input logic r, input logic s, input logic v, input logic [25:0] d);
        bit          el, it, was_full;
        logic [19:0] ti;
        rst = r; st = s; in_valid = v; in_rec = d;
        #1;
        el = m_run && mq.size() > 0 && int'(mq[0][25:20]) <= m_tmr;
        it = el ? (mq[0][19:16] != 4'd0) : 1'b0;
        ti = it ? mq[0][19:0] : 20'd0;
        chk("inputtask", 32'(inputtask), 32'(it));
        chk("task_in", 32'(task_in), 32'(ti));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("pending", 32'(pending), 32'(mq.size() > 0));
        chk("late_cnt", 32'(late_cnt), 32'(stat(m_late)));
        chk("drop_cnt", 32'(drop_cnt), 32'(stat(m_drop)));
        @(posedge clk);
        was_full = (mq.size() == DEPTH);
        if (r) begin
            model_clear();
        end else begin
            if (el) begin
                if (mq[0][19:16] == 4'd0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else if (int'(mq[0][25:20]) < m_tmr) m_late = (m_late < 255) ? m_late + 1 : 255;
                void'(mq.pop_front());
            end
            if (v && !was_full) mq.push_back(d);
            if (m_run) m_tmr = (m_tmr + 1) % 64;
            else if (s) begin m_run = 1; m_tmr = 0; end
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 26'd0);
    endtask

    initial begin
        // Two preloaded records, then a burst-0 record followed by a late one.
        tbl[0]  = mk(0, 0, 1, rec(0, 3, 16'h0001), 0, 20'h0,     1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, rec(2, 1, 16'h0002), 0, 20'h0,     1, 1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 26'd0,               0, 20'h0,     1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 26'd0,               1, 20'h30001, 1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 26'd0,               0, 20'h0,     1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 26'd0,               1, 20'h10002, 1, 1, 0, 0);
        tbl[6]  = mk(1, 0, 0, 26'd0,               0, 20'h0,     1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, rec(1, 0, 16'h00BB), 0, 20'h0,     1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, rec(1, 2, 16'h00AA), 0, 20'h0,     1, 1, 0, 0);
        tbl[9]  = mk(0, 1, 0, 26'd0,               0, 20'h0,     1, 1, 0, 0);
        tbl[10] = mk(0, 0, 0, 26'd0,               0, 20'h0,     1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 26'd0,               0, 20'h0,     1, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 26'd0,               1, 20'h200AA, 1, 1, 0, 1);
        tbl[13] = mk(0, 0, 0, 26'd0,               0, 20'h0,     1, 0, 1, 1);

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_inputtask", 32'(inputtask), 32'd0);
        chk("rst_task_in", 32'(task_in), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_late", 32'(late_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].r; st = tbl[i].s; in_valid = tbl[i].v; in_rec = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_inputtask", i), 32'(inputtask), 32'(tbl[i].it));
            chk($sformatf("tbl%0d_task_in", i), 32'(task_in), 32'(tbl[i].ti));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_late", i), 32'(late_cnt), 32'(stat(int'(tbl[i].late))));
            chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(stat(int'(tbl[i].drop))));
            @(posedge clk); #1;
        end

        // Three records at arrival 0 serialise over three cycles.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, rec(0, i + 1, 16'h0100 + i));
        cycle(0, 1, 0, 26'd0);
        repeat (4) idle();
        chk("serial_late", 32'(late_cnt), 32'(stat(2)));

        // Fill the FIFO; extra push ignored; ready returns after the first pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, rec(5, 1, 16'h0200 + i));
        chk("full_ready", 32'(in_ready), 32'd0);
        cycle(0, 0, 1, rec(5, 1, 16'h0099));
        cycle(0, 1, 0, 26'd0);
        repeat (5) idle();
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        chk("full_first_pop", 32'(inputtask), 32'd1);
        idle();
        chk("full_ready_back", 32'(in_ready), 32'd1);
        repeat (DEPTH + 2) idle();

        // Reset in RUN cycle 5 with three records pending.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, rec(20, 2, 16'h0300 + i));
        cycle(0, 1, 0, 26'd0);
        repeat (5) idle();
        cycle(1, 0, 0, 26'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_inputtask", 32'(inputtask), 32'd0);
        chk("midrst_late", 32'(late_cnt), 32'd0);
        cycle(0, 0, 1, rec(0, 2, 16'h0055));
        repeat (4) idle();
        chk("midrst_no_strobe", 32'(inputtask), 32'd0);
        cycle(0, 1, 0, 26'd0);
        idle();

        // Record pushed after its arrival time; then timer wrap.
        do_reset();
        cycle(0, 1, 0, 26'd0);
        repeat (10) idle();
        cycle(0, 0, 1, rec(3, 4, 16'h00CC));
        chk("late_push_strobe", 32'(inputtask), 32'd1);
        chk("late_push_task", 32'(task_in), 32'h400CC);
        idle();
        chk("late_push_cnt", 32'(late_cnt), 32'(stat(1)));
        for (int n = 0; n < 64 && m_tmr != 60; n++) idle();
        cycle(0, 0, 1, rec(62, 1, 16'h00E1));
        idle(); idle();
        cycle(0, 0, 1, rec(5, 1, 16'h00E3));
        repeat (8) idle();

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic r, s, v;
            int   arr;
            r   = ($urandom_range(0, 299) == 0);
            s   = !m_run && ($urandom_range(0, 9) == 0);
            v   = ($urandom_range(0, 2) == 0);
            arr = (m_tmr + $urandom_range(0, 6)) % 64;
            cycle(r, s, v, rec(arr, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15),
                               $urandom_range(0, 65535)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
